// File: rtl/i2c_slave_fifo_if.sv
// rtl/i2c_slave_fifo_if.sv - I2C target bridging master writes to an RX FIFO and master reads from a TX FIFO
// Ports:
//   clk, rst              system clock (>= 8x SCL), async active-high reset
//   scl_in, sda_in        raw asynchronous bus pads
//   sda_oe                open-drain SDA pull-down enable
//   rx_wr_en/rx_wr_data   push port of the RX FIFO, rx_wr_full its full flag
//   tx_rd_en/tx_rd_data   pop port of a show-ahead TX FIFO, tx_rd_empty its empty flag
//   busy                  addressed transfer in progress (match .. STOP)
//   rx_overflow           pulse: written byte dropped, RX FIFO full
//   tx_underrun           pulse: read byte requested, TX FIFO empty (0xFF sent)
module i2c_slave_fifo_if #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         DSIZE      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             rx_wr_en,
    output logic [DSIZE-1:0] rx_wr_data,
    input  logic             rx_wr_full,
    output logic             tx_rd_en,
    input  logic [DSIZE-1:0] tx_rd_data,
    input  logic             tx_rd_empty,
    output logic             busy,
    output logic             rx_overflow,
    output logic             tx_underrun
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_WR_DATA   = 3'd2;
    localparam logic [2:0] ST_RD_DATA   = 3'd3;
    localparam logic [2:0] ST_WAIT_STOP = 3'd4;

    logic             r_scl_s1, r_scl_s2, r_scl_h;
    logic             r_sda_s1, r_sda_s2, r_sda_h;
    logic [2:0]       r_state;
    logic [2:0]       r_bit_cnt;
    logic             r_ack_phase;   // between the 8th rise and the 9th fall
    logic             r_ack_rose;    // 9th rise already seen inside the ack phase
    logic             r_ack_pend;    // we ACK this byte during the 9th bit
    logic [DSIZE-2:0] r_shift;
    logic [DSIZE-1:0] r_tx;
    logic             r_sda_oe, r_rx_wr_en, r_tx_rd_en, r_busy, r_rx_overflow, r_tx_underrun;
    logic [DSIZE-1:0] r_rx_wr_data;

    logic             w_scl_rise, w_scl_fall, w_start, w_stop, w_last_bit;
    logic [DSIZE-1:0] w_byte;

    // Synchronizers preset to the idle-bus level so reset release never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_h <= 1'b1;
            r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_h <= 1'b1;
        end else begin
            r_scl_s1 <= scl_in; r_scl_s2 <= r_scl_s1; r_scl_h <= r_scl_s2;
            r_sda_s1 <= sda_in; r_sda_s2 <= r_sda_s1; r_sda_h <= r_sda_s2;
        end
    end

    assign w_scl_rise = r_scl_s2 & ~r_scl_h;
    assign w_scl_fall = ~r_scl_s2 & r_scl_h;
    assign w_start    = r_scl_s2 & r_scl_h & ~r_sda_s2 & r_sda_h;
    assign w_stop     = r_scl_s2 & r_scl_h & r_sda_s2 & ~r_sda_h;
    assign w_byte     = {r_shift, r_sda_s2};
    assign w_last_bit = (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 3'd0;
            r_ack_phase   <= 1'b0;
            r_ack_rose    <= 1'b0;
            r_ack_pend    <= 1'b0;
            r_shift       <= '0;
            r_tx          <= '1;
            r_sda_oe      <= 1'b0;
            r_rx_wr_en    <= 1'b0;
            r_rx_wr_data  <= '0;
            r_tx_rd_en    <= 1'b0;
            r_busy        <= 1'b0;
            r_rx_overflow <= 1'b0;
            r_tx_underrun <= 1'b0;
        end else begin
            r_rx_wr_en    <= 1'b0;
            r_tx_rd_en    <= 1'b0;
            r_rx_overflow <= 1'b0;
            r_tx_underrun <= 1'b0;
            if (w_start) begin
                r_state     <= ST_ADDR;
                r_bit_cnt   <= 3'd0;
                r_ack_phase <= 1'b0;
                r_ack_rose  <= 1'b0;
                r_ack_pend  <= 1'b0;
                r_sda_oe    <= 1'b0;
            end else if (w_stop) begin
                r_state     <= ST_IDLE;
                r_ack_phase <= 1'b0;
                r_ack_rose  <= 1'b0;
                r_ack_pend  <= 1'b0;
                r_sda_oe    <= 1'b0;
                r_busy      <= 1'b0;
            end else if (r_state != ST_IDLE) begin
                if (w_scl_rise) begin
                    if (!r_ack_phase) begin
                        r_shift   <= w_byte[DSIZE-2:0];
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_last_bit) begin
                            r_ack_phase <= 1'b1;
                            r_ack_rose  <= 1'b0;
                            case (r_state)
                                ST_ADDR: begin
                                    if (w_byte[DSIZE-1:1] == SLAVE_ADDR) begin
                                        r_busy     <= 1'b1;
                                        r_ack_pend <= 1'b1;
                                        if (w_byte[0]) begin
                                            r_state <= ST_RD_DATA;
                                            if (!tx_rd_empty) begin
                                                r_tx       <= tx_rd_data;
                                                r_tx_rd_en <= 1'b1;
                                            end else begin
                                                r_tx          <= '1;
                                                r_tx_underrun <= 1'b1;
                                            end
                                        end else begin
                                            r_state <= ST_WR_DATA;
                                        end
                                    end else begin
                                        r_state <= ST_WAIT_STOP;
                                    end
                                end
                                ST_WR_DATA: begin
                                    if (!rx_wr_full) begin
                                        r_rx_wr_data <= w_byte;
                                        r_rx_wr_en   <= 1'b1;
                                        r_ack_pend   <= 1'b1;
                                    end else begin
                                        r_rx_overflow <= 1'b1;
                                        r_state       <= ST_WAIT_STOP;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end else begin
                        // 9th rise: in a read data byte this samples the master's ACK/NACK.
                        r_ack_rose <= 1'b1;
                        if (r_state == ST_RD_DATA && !r_ack_pend) begin
                            if (!r_sda_s2) begin
                                if (!tx_rd_empty) begin
                                    r_tx       <= tx_rd_data;
                                    r_tx_rd_en <= 1'b1;
                                end else begin
                                    r_tx          <= '1;
                                    r_tx_underrun <= 1'b1;
                                end
                            end else begin
                                r_state <= ST_WAIT_STOP;
                            end
                        end
                    end
                end else if (w_scl_fall) begin
                    if (r_ack_phase && !r_ack_rose) begin
                        // 8th fall: start our ACK, or release SDA for the master's ACK.
                        r_sda_oe <= r_ack_pend;
                    end else begin
                        if (r_ack_phase) begin
                            r_ack_phase <= 1'b0;
                            r_ack_pend  <= 1'b0;
                        end
                        if (r_state == ST_RD_DATA) begin
                            r_sda_oe <= ~r_tx[DSIZE-1];
                            r_tx     <= {r_tx[DSIZE-2:0], 1'b1};
                        end else begin
                            r_sda_oe <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign sda_oe      = r_sda_oe;
    assign rx_wr_en    = r_rx_wr_en;
    assign rx_wr_data  = r_rx_wr_data;
    assign tx_rd_en    = r_tx_rd_en;
    assign busy        = r_busy;
    assign rx_overflow = r_rx_overflow;
    assign tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_i2c_slave_fifo_if.sv
// tb/tb_i2c_slave_fifo_if.sv - bit-banged I2C master bench with FIFO models and transaction-level reference
module tb_i2c_slave_fifo_if;

    localparam logic [6:0] SA = 7'h50;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       sda_bus;
    logic       sda_oe, rx_wr_en, rx_wr_full, tx_rd_en, tx_rd_empty;
    logic       busy, rx_overflow, tx_underrun;
    logic [7:0] rx_wr_data, tx_rd_data;

    always #5 clk = ~clk;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_slave_fifo_if #(.SLAVE_ADDR(SA), .DSIZE(8)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_bus), .sda_oe(sda_oe),
        .rx_wr_en(rx_wr_en), .rx_wr_data(rx_wr_data), .rx_wr_full(rx_wr_full),
        .tx_rd_en(tx_rd_en), .tx_rd_data(tx_rd_data), .tx_rd_empty(tx_rd_empty),
        .busy(busy), .rx_overflow(rx_overflow), .tx_underrun(tx_underrun)
    );

    // TX FIFO model: memory and write pointer owned by the stimulus, read pointer by the monitor.
    logic [7:0] tx_mem [0:255];
    int         tx_wr_ptr = 0;
    int         tx_rd_ptr = 0;
    assign tx_rd_empty = (tx_rd_ptr == tx_wr_ptr);
    assign tx_rd_data  = tx_rd_empty ? 8'h3C : tx_mem[tx_rd_ptr[7:0]];

    logic [7:0] rx_log [$];
    int n_push = 0, n_pop = 0, n_ovf = 0, n_und = 0, n_both = 0, n_oe = 0, n_busy = 0;

    always @(negedge clk) begin
        if (tx_rd_en && !tx_rd_empty) tx_rd_ptr <= tx_rd_ptr + 1;
        if (rx_wr_en) rx_log.push_back(rx_wr_data);
        n_push <= n_push + (rx_wr_en ? 1 : 0);
        n_pop  <= n_pop  + (tx_rd_en ? 1 : 0);
        n_ovf  <= n_ovf  + (rx_overflow ? 1 : 0);
        n_und  <= n_und  + (tx_underrun ? 1 : 0);
        n_both <= n_both + ((rx_wr_en && tx_rd_en) ? 1 : 0);
        n_oe   <= n_oe   + (sda_oe ? 1 : 0);
        n_busy <= n_busy + (busy ? 1 : 0);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    int s_push, s_pop, s_ovf, s_und, s_oe, s_busy;
    task automatic snap();
        s_push = n_push; s_pop = n_pop; s_ovf = n_ovf; s_und = n_und; s_oe = n_oe; s_busy = n_busy;
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic r);
        sda_m = b;  wt(5);
        scl_m = 1'b1; wt(5);
        r = sda_bus; wt(5);
        scl_m = 1'b0; wt(5);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
        clock_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, r);
            d[i] = r;
        end
        clock_bit(~mack, r);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wt(5);
        scl_m = 1'b1; wt(5);
        sda_m = 1'b0; wt(5);
        scl_m = 1'b0; wt(5);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wt(5);
        scl_m = 1'b1; wt(5);
        sda_m = 1'b1; wt(10);
    endtask

    logic [7:0] pay    [0:3];
    logic       full_m [0:3];

    task automatic do_write(input logic [6:0] addr, input int n);
        logic [7:0] exp_q [$];
        logic       ack;
        logic       matched;
        int         base, ovf;
        logic [31:0] got;
        snap();
        base = rx_log.size();
        ovf = 0;
        matched = (addr == SA);
        bus_start();
        write_byte({addr, 1'b0}, ack);
        chk("wr_addr_ack", ack, matched);
        for (int i = 0; i < n; i++) begin
            rx_wr_full = full_m[i];
            write_byte(pay[i], ack);
            rx_wr_full = 1'b0;
            if (!matched) chk("nomatch_data_ack", ack, 0);
            else if (full_m[i]) begin
                chk("ovf_nack", ack, 0);
                ovf++;
                break;
            end else begin
                chk("wr_data_ack", ack, 1);
                exp_q.push_back(pay[i]);
            end
        end
        chk("wr_busy_before_stop", busy, matched);
        bus_stop();
        chk("wr_busy_after_stop", busy, 0);
        chk("push_count", n_push - s_push, exp_q.size());
        for (int j = 0; j < exp_q.size(); j++) begin
            got = (base + j < rx_log.size()) ? 32'(rx_log[base + j]) : 32'hDEAD;
            chk("push_data", got, exp_q[j]);
        end
        chk("ovf_count", n_ovf - s_ovf, ovf);
        chk("wr_pop_count", n_pop - s_pop, 0);
        chk("wr_und_count", n_und - s_und, 0);
        if (!matched) begin
            chk("nomatch_wr_oe_cycles", n_oe - s_oe, 0);
            chk("nomatch_wr_busy_cycles", n_busy - s_busy, 0);
        end
    endtask

    task automatic do_read(input logic [6:0] addr, input int k, input int n);
        logic       ack;
        logic       matched;
        logic [7:0] d;
        int         exp_pop, exp_und;
        snap();
        matched = (addr == SA);
        tx_wr_ptr = tx_rd_ptr;
        for (int j = 0; j < k; j++) tx_mem[(tx_wr_ptr + j) & 255] = pay[j];
        tx_wr_ptr = tx_wr_ptr + k;
        bus_start();
        write_byte({addr, 1'b1}, ack);
        chk("rd_addr_ack", ack, matched);
        if (matched) begin
            for (int j = 0; j < n; j++) begin
                read_byte(j < n - 1, d);
                chk("rd_byte", d, (j < k) ? pay[j] : 8'hFF);
            end
            chk("rd_busy", busy, 1);
            chk("rd_release_after_nack", sda_oe, 0);
        end
        bus_stop();
        chk("rd_busy_after_stop", busy, 0);
        exp_pop = matched ? ((n < k) ? n : k) : 0;
        exp_und = matched ? ((n > k) ? n - k : 0) : 0;
        chk("rd_pop_count", n_pop - s_pop, exp_pop);
        chk("rd_und_count", n_und - s_und, exp_und);
        chk("rd_push_count", n_push - s_push, 0);
        if (!matched) chk("nomatch_rd_oe_cycles", n_oe - s_oe, 0);
        tx_wr_ptr = tx_rd_ptr;
    endtask

    initial begin
        logic       ack, r;
        logic [7:0] d;
        logic [6:0] addr;
        int         kind, base;

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rx_wr_full = 1'b0;
        for (int i = 0; i < 4; i++) full_m[i] = 1'b0;
        wt(3);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rx_wr_en", rx_wr_en, 0);
        chk("rst_tx_rd_en", tx_rd_en, 0);
        chk("rst_rx_overflow", rx_overflow, 0);
        chk("rst_tx_underrun", tx_underrun, 0);
        chk("rst_rx_wr_data", rx_wr_data, 0);
        rst = 1'b0;
        wt(5);

        pay[0] = 8'h12; pay[1] = 8'h34;
        do_write(SA, 2);

        pay[0] = 8'h55;
        do_write(7'h51, 1);

        pay[0] = 8'hC3; pay[1] = 8'h5A;
        do_read(SA, 2, 2);

        pay[0] = 8'h11; pay[1] = 8'h22; full_m[1] = 1'b1;
        do_write(SA, 2);
        full_m[1] = 1'b0;

        do_read(SA, 0, 1);

        // Repeated START in the middle of a write byte, then a read.
        snap();
        base = rx_log.size();
        tx_wr_ptr = tx_rd_ptr;
        tx_mem[tx_wr_ptr & 255] = 8'h96;
        tx_wr_ptr = tx_wr_ptr + 1;
        bus_start();
        write_byte({SA, 1'b0}, ack);
        chk("rs_wr_addr_ack", ack, 1);
        write_byte(8'h77, ack);
        chk("rs_wr_data_ack", ack, 1);
        for (int i = 0; i < 3; i++) clock_bit(1'b0, r);
        bus_start();
        write_byte({SA, 1'b1}, ack);
        chk("rs_rd_addr_ack", ack, 1);
        read_byte(1'b0, d);
        chk("rs_rd_byte", d, 8'h96);
        bus_stop();
        chk("rs_push_count", n_push - s_push, 1);
        chk("rs_push_data", (base < rx_log.size()) ? 32'(rx_log[base]) : 32'hDEAD, 8'h77);
        chk("rs_pop_count", n_pop - s_pop, 1);
        tx_wr_ptr = tx_rd_ptr;

        // Reset while driving a read bit low.
        tx_mem[tx_wr_ptr & 255] = 8'h00;
        tx_wr_ptr = tx_wr_ptr + 1;
        bus_start();
        write_byte({SA, 1'b1}, ack);
        chk("rst_rd_addr_ack", ack, 1);
        clock_bit(1'b1, r);
        clock_bit(1'b1, r);
        chk("oe_before_rst", sda_oe, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sda_oe", sda_oe, 0);
        chk("async_rst_busy", busy, 0);
        scl_m = 1'b1; sda_m = 1'b1;
        wt(5);
        rst = 1'b0;
        wt(5);
        tx_wr_ptr = tx_rd_ptr;
        pay[0] = 8'hA5;
        do_write(SA, 1);

        for (int it = 0; it < 20; it++) begin
            kind = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) begin
                pay[i]    = 8'($urandom_range(0, 255));
                full_m[i] = ($urandom_range(0, 3) == 0);
            end
            addr = 7'($urandom_range(0, 127));
            if (addr == SA) addr = 7'h00;
            case (kind)
                0, 1: do_write(SA, $urandom_range(1, 3));
                2: do_read(SA, $urandom_range(0, 3), $urandom_range(1, 3));
                default: begin
                    if ($urandom_range(0, 1) == 0) do_write(addr, $urandom_range(1, 2));
                    else do_read(addr, $urandom_range(0, 3), 1);
                end
            endcase
            for (int i = 0; i < 4; i++) full_m[i] = 1'b0;
        end

        chk("dual_strobe_cycles", n_both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_slave_fifo_if.md
Name: i2c_slave_fifo_if

Overview:
- I2C target (responder) for the far end of our single-master bus.
- Bytes written by the master are pushed into an RX sync FIFO; bytes read by the master are popped from a TX sync FIFO.
- Single clk domain with oversampled SCL/SDA; open-drain SDA drive only; no clock stretching.
- Connects directly to the write port of one Sync_FIFO and the read port of another.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target responds to.
- DSIZE, 8, data byte width. Fixed at 8; any other value is illegal.

Ports:
- clk  input  1  system clock; must be ≥8x SCL frequency.
- rst  input  1  asynchronous reset, active-high.
- scl_in  input  1  raw SCL pad input (asynchronous).
- sda_in  input  1  raw SDA pad input (asynchronous).
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- rx_wr_en  output  1  one-cycle push strobe to RX FIFO.
- rx_wr_data  output  8  byte to push; valid when rx_wr_en=1.
- rx_wr_full  input  1  RX FIFO full.
- tx_rd_en  output  1  one-cycle pop strobe to TX FIFO.
- tx_rd_data  input  8  TX FIFO head; show-ahead, valid while tx_rd_empty=0.
- tx_rd_empty  input  1  TX FIFO empty.
- busy  output  1  high from address match until STOP.
- rx_overflow  output  1  one-cycle pulse: write byte dropped because RX FIFO full.
- tx_underrun  output  1  one-cycle pulse: read requested with TX FIFO empty.

Behaviour:
- Reset (async, any time, including mid-byte):
  - state=IDLE.
  - sda_oe, rx_wr_en, tx_rd_en, busy, rx_overflow, tx_underrun = 0; rx_wr_data = 0.
  - Synchronizers preset to 1 (idle bus).
- Input conditioning:
  - scl_in and sda_in each pass through a 2-flop synchronizer plus one history flop.
  - Rise/fall detect from synced vs. history.
  - All decisions use synced values.
- START: synced SDA falls while synced SCL high. Go to ADDR from any state, including mid-byte (repeated start). Clear bit counter; release sda_oe.
- STOP: synced SDA rises while synced SCL high. Go to IDLE from any state; release sda_oe; busy=0.
- Bit timing:
  - Sample on SCL rise.
  - Change sda_oe only in the clk cycle after SCL fall is detected.
  - MSB first; 3-bit counter; byte complete on the 8th rise.
- States and transitions:
  - IDLE: ignore bus until START.
  - ADDR: shift 7 address bits + R/W.
    - Match: busy=1; drive ACK (sda_oe=1) from the 8th SCL fall through the 9th SCL fall.
    - Mismatch: no ACK, no FIFO activity, go to WAIT_STOP.
  - ADDR ACK with R/W=0: go to WR_DATA.
  - ADDR ACK with R/W=1: go to RD_DATA.
    - On the 8th rise, if tx_rd_empty=0: load shift register from tx_rd_data and pulse tx_rd_en.
    - Else: load 8'hFF, pulse tx_underrun, no pop.
  - WR_DATA, on the 8th rise:
    - rx_wr_full=0: rx_wr_data=byte, rx_wr_en=1 for exactly one clk; ACK during the 9th bit; remain in WR_DATA.
    - rx_wr_full=1: no push, pulse rx_overflow, NACK (sda_oe stays 0), go to WAIT_STOP.
  - RD_DATA:
    - Drive sda_oe = ~bit at each SCL fall, starting on the ACK-phase fall.
    - After the 8th bit's fall, release SDA for the master ACK.
    - Master ACK (SDA=0 on 9th rise): fetch next byte (pop or underrun rule as above), continue RD_DATA.
    - Master NACK: release SDA, go to WAIT_STOP.
  - WAIT_STOP: sda_oe=0; wait for STOP or START.
- Pulses:
  - rx_wr_en, tx_rd_en, rx_overflow and tx_underrun are single-cycle, at most once per byte.
  - rx_wr_en and tx_rd_en never assert in the same cycle.
- Latency: a FIFO strobe occurs ≤4 clk after the raw SCL edge that completes the byte.
- General call (address 0): NACKed like any mismatch.

Test Plan:
- Write 0xA0, 0x12, 0x34, STOP → ACK on all three bytes; rx_wr_en pulses twice, with data 0x12 then 0x34; busy 1→0 at STOP.
- Address byte 0xA2 (0x51, W), then 0x55 → sda_oe=0 for the entire transfer; no strobes; busy stays 0.
- TX FIFO holds 0xC3, 0x5A; master sends 0xA1, reads with ACK then NACK, STOP → SDA shows 11000011 then 01011010; tx_rd_en pulses exactly twice; SDA released after NACK.
- Write 0xA0, 0x11, then 0x22 with rx_wr_full=1 → 0x11 ACKed and pushed; 0x22 NACKed; rx_overflow pulses once; no second push.
- Read 0xA1 with tx_rd_empty=1 → bus carries 0xFF; tx_underrun pulses; tx_rd_en stays 0.
- Repeated START mid-byte during a write, then 0xA1 read; rst pulsed while driving a read bit → ADDR restarts cleanly; on rst, sda_oe=0 asynchronously and state=IDLE.
